dtack_gen: RTL

- Synchronous 68000 bus-cycle terminator and address decoder.
- Decodes A23:A20 into active-low chip selects and generates /DTACK after a per-region wait-state count.
- Upstream of the bus error watchdog: unmapped regions never get /DTACK, so the watchdog's /BERR ends the cycle. /BERR is also consumed here to abort the cycle.
- Provides a boot overlay so the reset vector fetch at address 0 reads ROM.

---
 rtl/dtack_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dtack_gen.sv
// dtack_gen: 68000 address decoder and /DTACK generator with per-region wait states.
// Define BOOT_OVERLAY_EN to map region 0x0 to ROM for the first BOOT_CYCLES bus cycles.
module dtack_gen #(
  parameter int RAM_WAIT    = 0,
  parameter int ROM_WAIT    = 2,
  parameter int IO_WAIT     = 4,
  parameter int WS_W        = 3,
  parameter int BOOT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       as,
  input  logic       uds,
  input  logic       lds,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic       berr,
  output logic       dtack,
  output logic       ram_cs,
  output logic       rom_cs,
  output logic       io_cs,
  output logic       oe,
  output logic       we_u,
  output logic       we_l
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;
  typedef enum logic [1:0] {RG_RAM, RG_ROM, RG_IO, RG_UNM} region_t;

  logic            r_as_s1;
  logic            r_as_s2;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [WS_W-1:0] r_cnt;
  logic [WS_W-1:0] w_cnt_nxt;
  region_t         r_region;
  region_t         w_region_nxt;
  region_t         w_decode;
  logic [2:0]      r_cs;        // {io, rom, ram}, active-low
  logic [2:0]      w_cs_nxt;
  logic            r_dtack;
  logic            w_dtack_nxt;
  logic            w_overlay;
  logic            w_cs_any;

`ifdef BOOT_OVERLAY_EN
  localparam int BW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_MAX = BW'(BOOT_CYCLES);

  logic [BW-1:0] r_boot;
  logic          w_boot_inc;

  // Every cycle that reached ACK or was terminated through HOLD counts.
  assign w_boot_inc = ((r_state == S_ACK) || (r_state == S_HOLD)) && (w_state_nxt == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_boot <= '0;
    end else if (w_boot_inc && (r_boot != BOOT_MAX)) begin
      r_boot <= r_boot + 1'b1;
    end
  end

  assign w_overlay = (r_boot != BOOT_MAX);
`else
  // BOOT_CYCLES is inert in this build: the overlay never applies.
  assign w_overlay = (BOOT_CYCLES < 0);
`endif

  always_comb begin
    w_decode = RG_UNM;
    if (!addr[3]) begin
      w_decode = ((addr == 4'h0) && w_overlay) ? RG_ROM : RG_RAM;
    end else if (addr == 4'hE) begin
      w_decode = RG_ROM;
    end else if (addr == 4'hF) begin
      w_decode = RG_IO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_as_s1  <= 1'b1;
      r_as_s2  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_region <= RG_UNM;
      r_cs     <= 3'b111;
      r_dtack  <= 1'b1;
    end else begin
      r_as_s1  <= as;
      r_as_s2  <= r_as_s1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_region <= w_region_nxt;
      r_cs     <= w_cs_nxt;
      r_dtack  <= w_dtack_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_region_nxt = r_region;
    w_cs_nxt     = r_cs;
    unique case (r_state)
      S_IDLE: begin
        if (!r_as_s2) begin
          w_region_nxt = w_decode;
          unique case (w_decode)
            RG_RAM:  w_cnt_nxt = WS_W'(RAM_WAIT);
            RG_ROM:  w_cnt_nxt = WS_W'(ROM_WAIT);
            RG_IO:   w_cnt_nxt = WS_W'(IO_WAIT);
            default: w_cnt_nxt = '0;
          endcase
          w_state_nxt = (w_decode == RG_UNM) ? S_HOLD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_as_s2) begin
          w_state_nxt = S_IDLE;
        end else if (!berr) begin
          w_state_nxt = S_HOLD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ACK: begin
        if (r_as_s2) begin
          w_state_nxt = S_IDLE;
        end else if (!berr) begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        if (r_as_s2) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase

    // Chip select is raised one edge after T0 and then held until the cycle ends.
    if (w_state_nxt == S_IDLE) begin
      w_cs_nxt = 3'b111;
    end else if (r_state == S_WAIT) begin
      unique case (r_region)
        RG_RAM:  w_cs_nxt = 3'b110;
        RG_ROM:  w_cs_nxt = 3'b101;
        RG_IO:   w_cs_nxt = 3'b011;
        default: w_cs_nxt = 3'b111;
      endcase
    end
    w_dtack_nxt = (w_state_nxt != S_ACK);
  end

  assign dtack  = r_dtack;
  assign ram_cs = r_cs[0];
  assign rom_cs = r_cs[1];
  assign io_cs  = r_cs[2];

  assign w_cs_any = (r_cs != 3'b111);
  assign oe       = !(w_cs_any & rw & (!uds | !lds));
  assign we_u     = !(w_cs_any & !rw & !uds);
  assign we_l     = !(w_cs_any & !rw & !lds);

endmodule
